vect_dot_accum: RTL and testbench

Downstream reduction stage for the Booth vector multiplier: consumes the stream of signed per-element products of an N-element vector pair and sums them into a saturated signed dot product. It accepts one product per cycle under a valid/ready handshake and counts elements itself. It presents the finished sum on a held output handshake for the consumer (scaler or writeback).

---
 rtl/vect_dot_accum_if.sv | 23 ++
 rtl/vect_dot_accum.sv | 124 ++++++++++++
 tb/tb_vect_dot_accum.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/vect_dot_accum_if.sv
// rtl/vect_dot_accum_if.sv - product input stream and held result handshake for the dot-product accumulator
interface vect_dot_accum_if #(
    parameter int PW    = 12,
    parameter int ACC_W = 12
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [PW-1:0]    in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_sum;
    logic                    out_ovf;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/vect_dot_accum.sv
// rtl/vect_dot_accum.sv - sums N signed products into a saturated dot product with held result handshake
module vect_dot_accum #(
    parameter int N     = 4,
    parameter int M     = 4,
    parameter int ACC_W = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                err,
    vect_dot_accum_if.slave     io
);
    localparam int PW = 3 * M;
    localparam int CW = $clog2(N);
    localparam int AW = PW + CW;

    // Saturation bounds of the ACC_W result, expressed in accumulator width
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state, state_n;
    logic signed [AW-1:0]    acc;
    logic [CW-1:0]           cnt;
    logic signed [AW-1:0]    in_ext;
    logic signed [AW-1:0]    sum_n;
    logic signed [ACC_W-1:0] sat_sum;
    logic                    sat_ovf;
    logic                    acc_clr;
    logic                    acc_add;
    logic                    load_out;
    logic                    err_n;

    assign in_ext       = {{(AW-PW){io.in_data[PW-1]}}, io.in_data};
    assign sum_n        = acc + in_ext;
    assign io.in_ready  = (state == ACCUM);
    assign io.out_valid = (state == HOLD);
    assign busy         = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        load_out = 1'b0;
        err_n    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ACCUM;
                    acc_clr = 1'b1;
                end
            end
            ACCUM: begin
                // An aborting start wins over a product offered in the same cycle
                if (start) begin
                    acc_clr = 1'b1;
                    err_n   = 1'b1;
                end else if (io.in_valid) begin
                    acc_add = 1'b1;
                    if (cnt == CW'(N-1)) begin
                        state_n  = HOLD;
                        load_out = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (io.out_ready) begin
                    if (start) begin
                        state_n = ACCUM;
                        acc_clr = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        sat_sum = sum_n[ACC_W-1:0];
        sat_ovf = 1'b0;
        if (sum_n > SAT_MAX) begin
            sat_sum = SAT_MAX[ACC_W-1:0];
            sat_ovf = 1'b1;
        end else if (sum_n < SAT_MIN) begin
            sat_sum = SAT_MIN[ACC_W-1:0];
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            io.out_sum <= '0;
            io.out_ovf <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= err_n;
            if (acc_clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (acc_add) begin
                acc <= sum_n;
                cnt <= load_out ? '0 : cnt + CW'(1);
            end
            if (load_out) begin
                io.out_sum <= sat_sum;
                io.out_ovf <= sat_ovf;
            end
        end
    end
endmodule

// File: tb/tb_vect_dot_accum.sv
// tb/tb_vect_dot_accum.sv - randomized and directed self-checking bench for vect_dot_accum
module tb_vect_dot_accum;
    localparam int N     = 4;
    localparam int M     = 4;
    localparam int PW    = 3 * M;
    localparam int ACC_W = 12;
    localparam int SMAX  = (1 << (ACC_W - 1)) - 1;
    localparam int SMIN  = -(1 << (ACC_W - 1));

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic err;

    vect_dot_accum_if #(.PW(PW), .ACC_W(ACC_W)) io ();

    vect_dot_accum #(.N(N), .M(M), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (busy),
        .err   (err),
        .io    (io.slave)
    );

    int  n_cmp;
    int  n_bad;
    int  err_seen;
    int  err_exp;
    int  prod [N];
    int  exp_sum;
    int  exp_ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (err) err_seen++;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: exact integer sum of the vector, then clamp to ACC_W
    task automatic model();
        longint s = 0;
        for (int i = 0; i < N; i++) s += prod[i];
        exp_ovf = 0;
        if (s > SMAX) begin
            exp_sum = SMAX;
            exp_ovf = 1;
        end else if (s < SMIN) begin
            exp_sum = SMIN;
            exp_ovf = 1;
        end else begin
            exp_sum = int'(s);
        end
    endtask

    task automatic open_vec();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_ready", io.in_ready, 1);
        chk("start_busy", busy, 1);
    endtask

    task automatic feed(input logic [15:0] pat, input int len);
        int k = 0;
        model();
        for (int j = 0; j < len; j++) begin
            chk("feed_out_valid", io.out_valid, 0);
            if (pat[j] && k < N) begin
                io.in_valid = 1'b1;
                io.in_data  = PW'(prod[k]);
                k++;
            end else begin
                io.in_valid = 1'b0;
                io.in_data  = PW'($urandom);
            end
            tick();
        end
        io.in_valid = 1'b0;
        chk("result_latency", io.out_valid, 1);
        chk("out_sum", io.out_sum, exp_sum);
        chk("out_ovf", io.out_ovf, exp_ovf);
        chk("hold_in_ready", io.in_ready, 0);
    endtask

    task automatic rand_pat(output logic [15:0] pat, output int len);
        int k = 0;
        pat = '0;
        len = 0;
        while (k < N) begin
            if ($urandom_range(0, 2) == 0 && len < 16 - (N - k)) begin
                len++;
            end else begin
                pat[len] = 1'b1;
                len++;
                k++;
            end
        end
    endtask

    task automatic release_out(input int hold, input bit b2b);
        for (int h = 0; h < hold; h++) begin
            io.out_ready = 1'b0;
            start        = 1'($urandom_range(0, 1));
            tick();
            start = 1'b0;
            chk("hold_out_valid", io.out_valid, 1);
            chk("hold_out_sum", io.out_sum, exp_sum);
            chk("hold_out_ovf", io.out_ovf, exp_ovf);
        end
        io.out_ready = 1'b1;
        start        = b2b;
        tick();
        io.out_ready = 1'b0;
        start        = 1'b0;
        chk("release_out_valid", io.out_valid, 0);
        chk("release_busy", busy, b2b ? 1 : 0);
        chk("release_in_ready", io.in_ready, b2b ? 1 : 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, io.in_ready, 0);
        chk({tag, "_out_valid"}, io.out_valid, 0);
        chk({tag, "_out_sum"}, io.out_sum, 0);
        chk({tag, "_out_ovf"}, io.out_ovf, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        logic [15:0] pat;
        int          len;
        bit          opened;
        bit          b2b;

        n_cmp = 0; n_bad = 0; err_seen = 0; err_exp = 0;
        rst = 1'b1; start = 1'b0;
        io.in_valid = 1'b0; io.in_data = '0; io.out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Nominal vector with a three-cycle consumer stall
        prod = '{24, 0, -49, -24};
        open_vec(); feed(16'hF, N); release_out(3, 0);
        chk("nominal_sum", exp_sum, -49);

        prod = '{2047, 2047, 2047, 2047};
        open_vec(); feed(16'hF, N); release_out(0, 0);
        prod = '{-2048, -2048, -2048, -2048};
        open_vec(); feed(16'hF, N); release_out(0, 0);
        prod = '{2047, 2047, -2048, -2046};
        open_vec(); feed(16'hF, N); release_out(1, 0);

        // Bubbles: valid pattern 1,0,0,1,1,0,1
        prod = '{5, 6, 7, 8};
        open_vec(); feed(16'b1011001, 7); release_out(0, 0);

        // Abort: start coincides with a valid product, which is discarded
        open_vec();
        io.in_valid = 1'b1; io.in_data = PW'(100);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0; io.in_valid = 1'b0;
        err_exp++;
        chk("abort_err", err, 1);
        chk("abort_in_ready", io.in_ready, 1);
        prod = '{1, 2, 3, 4};
        feed(16'hF, N);
        chk("abort_err_once", err_seen, err_exp);
        release_out(0, 1);

        // Back-to-back second vector
        prod = '{1, 1, 1, 1};
        feed(16'hF, N); release_out(0, 0);

        // Reset after two products
        prod = '{9, 9, 9, 9};
        open_vec();
        io.in_valid = 1'b1; io.in_data = PW'(9);
        tick(); tick();
        io.in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrst");
        prod = '{3, 3, 3, 3};
        open_vec(); feed(16'hF, N); release_out(0, 0);

        // Randomized vectors, mixing full-range and near-saturation products
        opened = 1'b0;
        for (int v = 0; v < 40; v++) begin
            int mode = $urandom_range(0, 2);
            for (int i = 0; i < N; i++) begin
                case (mode)
                    0:       prod[i] = int'($urandom_range(0, 4095)) - 2048;
                    1:       prod[i] = 2047 - int'($urandom_range(0, 600));
                    default: prod[i] = -2048 + int'($urandom_range(0, 600));
                endcase
            end
            if (!opened) open_vec();
            rand_pat(pat, len);
            feed(pat, len);
            b2b = 1'($urandom_range(0, 1));
            release_out($urandom_range(0, 3), b2b);
            opened = b2b;
        end
        if (opened) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            err_exp++;
        end
        tick();
        chk("err_total", err_seen, err_exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
